// File: rtl/rv_iommu_axi4_bc_err.sv
// AXI4 4 KiB-style boundary checker for one address channel. Legal requests pass through.
// Illegal ones are absorbed, and this block generates the SLVERR response (R beats, or W drain + B).
module rv_iommu_axi4_bc_err #(
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned BOUNDARY_LOG2 = 12,
  parameter int unsigned IS_WRITE      = 0,
  parameter int unsigned ROUTE_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]            req_len_i,
  input  logic [2:0]            req_size_i,
  input  logic [1:0]            req_burst_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic                  err_valid_o,
  input  logic                  err_ready_i,
  output logic [ID_WIDTH-1:0]   err_id_o,
  output logic                  err_last_o
);

  localparam int unsigned CW = BOUNDARY_LOG2 + 12;
  localparam int unsigned PW = (ROUTE_DEPTH > 1) ? $clog2(ROUTE_DEPTH) : 1;
  localparam int unsigned NW = PW + 1;
  localparam logic [2:0] MaxSize = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [CW-1:0] Lim = CW'(1) << BOUNDARY_LOG2;

  typedef enum logic [0:0] {StRIdle, StRErr} r_state_e;

  // ---------------------------------------------------------------------------------------------
  // Legality check
  // ---------------------------------------------------------------------------------------------
  logic [CW-1:0] off, beat, span;
  logic          wrap_len_ok;
  logic          legal;
  logic          unused_addr_hi;

  assign off            = CW'(req_addr_i[BOUNDARY_LOG2-1:0]);
  assign beat           = CW'(1) << req_size_i;
  assign span           = (CW'(req_len_i) + CW'(1)) << req_size_i;
  assign wrap_len_ok    = (req_len_i == 8'd1) || (req_len_i == 8'd3) ||
                          (req_len_i == 8'd7) || (req_len_i == 8'd15);
  assign unused_addr_hi = ^req_addr_i[ADDR_WIDTH-1:BOUNDARY_LOG2];

  always_comb begin
    legal = 1'b0;
    case (req_burst_i)
      2'b00:   legal = (off + beat) <= Lim;
      2'b01:   legal = (off + span) <= Lim;
      2'b10:   legal = wrap_len_ok && ((off & (beat - CW'(1))) == '0) && (span <= Lim);
      default: legal = 1'b0;
    endcase
    if (req_size_i > MaxSize) legal = 1'b0;
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  r_state_e            state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] err_id_q, err_id_d;
  logic                b_valid_q, b_valid_d;
  logic [ID_WIDTH:0]   mem_q [ROUTE_DEPTH];
  logic [ID_WIDTH:0]   mem_d [ROUTE_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]       count_q, count_d;

  logic [ID_WIDTH:0]   head;
  logic                empty, full, not_full;
  logic                push, pop, load, w_rdy;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == NW'(ROUTE_DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_id_d    = err_id_q;
    b_valid_d   = b_valid_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    w_rdy       = 1'b0;
    not_full    = 1'b0;
    req_valid_o = 1'b0;
    req_ready_o = 1'b0;
    w_valid_o   = 1'b0;
    w_ready_o   = 1'b0;
    err_valid_o = 1'b0;
    err_id_o    = err_id_q;
    err_last_o  = 1'b0;

    if (IS_WRITE != 0) begin
      // W routing is resolved first so a wlast pop can free a full FIFO for a same-cycle push.
      if (!empty) begin
        if (!head[ID_WIDTH]) begin
          w_valid_o = w_valid_i;
          w_rdy     = w_ready_i;
          pop       = w_valid_i && w_ready_i && w_last_i;
        end else begin
          w_rdy = !(w_last_i && b_valid_q && !err_ready_i);
          pop   = w_valid_i && w_rdy && w_last_i;
          load  = pop;
        end
      end
      w_ready_o = w_rdy;
      not_full  = !full || pop;

      if (legal) begin
        req_valid_o = req_valid_i && not_full;
        req_ready_o = req_ready_i && not_full;
        push        = req_valid_i && req_ready_i && not_full;
      end else begin
        req_ready_o = not_full;
        push        = req_valid_i && not_full;
      end

      if (push) begin
        mem_d[wr_ptr_q] = {!legal, req_id_i};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + NW'(push) - NW'(pop);

      b_valid_d = (b_valid_q && !err_ready_i) || load;
      if (load) err_id_d = head[ID_WIDTH-1:0];
      err_valid_o = b_valid_q;
      err_last_o  = 1'b1;
    end else begin
      case (state_q)
        StRIdle: begin
          if (legal) begin
            req_valid_o = req_valid_i;
            req_ready_o = req_ready_i;
          end else begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
              state_d  = StRErr;
              err_id_d = req_id_i;
              cnt_d    = req_len_i;
            end
          end
        end
        StRErr: begin
          err_valid_o = 1'b1;
          err_last_o  = (cnt_q == 8'd0);
          if (err_ready_i) begin
            if (cnt_q == 8'd0) state_d = StRIdle;
            else               cnt_d   = cnt_q - 8'd1;
          end
        end
        default: state_d = StRIdle;
      endcase
    end

    // Outputs are held quiet for the whole reset, even though several are combinational.
    if (!rst_ni) begin
      req_valid_o = 1'b0;
      req_ready_o = 1'b0;
      w_valid_o   = 1'b0;
      w_ready_o   = 1'b0;
      err_valid_o = 1'b0;
      err_id_o    = '0;
      err_last_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRIdle;
      cnt_q     <= '0;
      err_id_q  <= '0;
      b_valid_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < ROUTE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_id_q  <= err_id_d;
      b_valid_q <= b_valid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

endmodule
